// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the CPU instruction memory.
// Assembles big-endian words, holds the CPU in reset while loading, and checks an XOR checksum.
//
// state   | meaning
// S_IDLE  | waiting for start; done/error hold the outcome of the last load
// S_HDR   | receive word count N (N=0 selects full depth)
// S_DATA  | receive payload bytes, lane 0 is the most significant byte
// S_WRITE | single-cycle instruction memory write of the assembled word
// S_CSUM  | receive checksum byte and compare against the accumulator
module imem_loader #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_CSUM} state_t;

  localparam bit              TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] hdr_n;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] index;
  logic [1:0]        lane;
  logic [7:0]        xor_acc;
  logic [23:0]       word_hi;
  logic [TO_W-1:0]   to_cnt;
  logic              rx_state;
  logic              xfer;
  logic              to_hit;

  always_comb begin
    rx_state  = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    in_ready  = rx_state;
    busy      = (state != S_IDLE);
    imem_we   = (state == S_WRITE);
    cpu_reset = reset | busy | error;
    xfer      = in_valid & in_ready;
    // N=0 wraps to all ones, which is the last index of a full-depth load
    last_idx  = hdr_n - ADDR_W'(1);
    to_hit    = TO_EN && rx_state && !in_valid && (to_cnt == TO_LAST);
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_HDR;
      S_HDR:   if (xfer) state_nxt = S_DATA;
      S_DATA:  if (xfer && (lane == 2'd3)) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (index == last_idx) ? S_CSUM : S_DATA;
      S_CSUM:  if (xfer) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (to_hit) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      hdr_n      <= '0;
      index      <= '0;
      lane       <= '0;
      xor_acc    <= '0;
      word_hi    <= '0;
      to_cnt     <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state == S_IDLE) && start) begin
        done    <= 1'b0;
        error   <= 1'b0;
        index   <= '0;
        lane    <= '0;
        xor_acc <= '0;
        to_cnt  <= '0;
      end

      if (rx_state) begin
        if (in_valid) to_cnt <= '0;
        else if (TO_EN) to_cnt <= to_cnt + 1'b1;
      end

      if (to_hit) error <= 1'b1;

      if (xfer) begin
        case (state)
          S_HDR: begin
            hdr_n   <= ADDR_W'(in_data);
            xor_acc <= xor_acc ^ in_data;
          end
          S_DATA: begin
            xor_acc <= xor_acc ^ in_data;
            lane    <= lane + 2'd1;
            case (lane)
              2'd0: word_hi[23:16] <= in_data;
              2'd1: word_hi[15:8]  <= in_data;
              2'd2: word_hi[7:0]   <= in_data;
              default: begin
                // address/data are presented through WRITE and then held
                imem_addr  <= index;
                imem_wdata <= {word_hi, in_data};
              end
            endcase
          end
          S_CSUM: begin
            if (in_data == xor_acc) done <= 1'b1;
            else error <= 1'b1;
          end
          default: ;
        endcase
      end

      if ((state == S_WRITE) && (state_nxt == S_DATA)) index <= index + ADDR_W'(1);
    end
  end

endmodule
